ft_cmd_initiator: RTL and testbench

FT_CMD_INITIATOR -- requirements
Module: ft_cmd_initiator

---
 rtl/ft_test_pkg.sv | 38 +++
 rtl/ft_cmd_ser.sv | 40 ++++
 rtl/ft_cmd_initiator.sv | 197 +++++++++++++++++++
 tb/tb_ft_cmd_initiator.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ft_test_pkg.sv
// Shared constants, opcode encoding and state enum for the FT command initiator.
package ft_test_pkg;

    localparam logic [15:0] CODE_TX_TEST = 16'hBEEF;
    localparam logic [15:0] CODE_RX_TEST = 16'hCAFE;
    localparam logic [15:0] CODE_LED     = 16'h1ED0;

    // First byte on the wire is the head, last byte is the tail.
    localparam logic [7:0] FRAME_HEAD  = 8'h55;
    localparam logic [7:0] FRAME_TAIL  = 8'hAA;
    localparam logic [7:0] STATUS_PASS = 8'h42;
    localparam logic [7:0] STATUS_FAIL = 8'hEE;

    typedef enum logic [1:0] {
        OP_TX_TEST = 2'd0,
        OP_RX_TEST = 2'd1,
        OP_LED     = 2'd2,
        OP_RSVD    = 2'd3
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEND_CMD,
        ST_SEND_DATA,
        ST_RECV_DATA,
        ST_RECV_STATUS,
        ST_FINISH
    } state_e;

    function automatic logic [15:0] op_code(input op_e op);
        case (op)
            OP_TX_TEST: op_code = CODE_TX_TEST;
            OP_RX_TEST: op_code = CODE_RX_TEST;
            default:    op_code = CODE_LED;
        endcase
    endfunction

endpackage

// File: rtl/ft_cmd_ser.sv
// 8-byte command frame serializer: load code/arg, then emit bytes on a valid/ready handshake.
module ft_cmd_ser
    import ft_test_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [15:0] code,
    input  logic [31:0] arg,
    input  logic        ready,
    output logic        valid,
    output logic [7:0]  data,
    output logic        last
);

    logic [63:0] frame_q;
    logic [2:0]  idx_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            frame_q <= '0;
            idx_q   <= '0;
            valid   <= 1'b0;
        end else if (load) begin
            frame_q <= {FRAME_HEAD, arg[7:0], arg[15:8], arg[23:16], arg[31:24],
                        code[7:0], code[15:8], FRAME_TAIL};
            idx_q   <= '0;
            valid   <= 1'b1;
        end else if (valid && ready) begin
            frame_q <= {frame_q[55:0], 8'h00};
            idx_q   <= idx_q + 3'd1;
            if (idx_q == 3'd7)
                valid <= 1'b0;
        end
    end

    assign data = frame_q[63:56];
    assign last = valid && ready && (idx_q == 3'd7);

endmodule

// File: rtl/ft_cmd_initiator.sv
// Test initiator: sends a command frame, then streams or checks payload and reports the result.
// state          | meaning
// ST_IDLE        | waiting for start
// ST_SEND_CMD    | serializer pushing the 8-byte frame
// ST_SEND_DATA   | RX_TEST payload k mod 256, k=0..N
// ST_RECV_DATA   | TX_TEST: read and compare N+1 response bytes
// ST_RECV_STATUS | RX_TEST: read the single status byte
// ST_FINISH      | one-cycle done pulse
module ft_cmd_initiator
    import ft_test_pkg::*;
#(
    parameter int DATA_W      = 8,
    parameter int TIMEOUT_CYC = 1_000_000
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic              start,
    input  logic [1:0]        op,
    input  logic [31:0]       arg,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [31:0]       err_cnt,
    output logic              timeout,
    output logic [DATA_W-1:0] tx_data,
    output logic              tx_wr,
    input  logic              tx_full,
    output logic              rx_rd,
    input  logic              rx_empty,
    input  logic [DATA_W-1:0] rx_data,
    input  logic              rx_valid
);

    state_e            state_q, state_d;
    op_e               op_q;
    logic [31:0]       n_q;
    logic [32:0]       beat_q;
    logic [DATA_W-1:0] exp_q, pay_q;
    logic [31:0]       tmo_q;
    logic [31:0]       arg_eff, err_next;
    logic              ser_load, ser_valid, ser_last;
    logic [7:0]        ser_data;
    logic              beat_last, tmo_hit, mismatch;

    assign arg_eff   = (op == OP_LED) ? {31'd0, arg[0]} : arg;
    assign beat_last = (beat_q == {1'b0, n_q});
    assign tmo_hit   = (tmo_q >= 32'(TIMEOUT_CYC - 1));
    assign mismatch  = (rx_data != exp_q);
    assign err_next  = (mismatch && err_cnt != 32'hFFFF_FFFF) ? err_cnt + 32'd1 : err_cnt;

    ft_cmd_ser u_ser (
        .clk   (sys_clk),
        .rst   (sys_rst),
        .load  (ser_load),
        .code  (op_code(op_e'(op))),
        .arg   (arg_eff),
        .ready (!tx_full),
        .valid (ser_valid),
        .data  (ser_data),
        .last  (ser_last)
    );

    always_comb begin
        state_d  = state_q;
        ser_load = 1'b0;
        tx_wr    = 1'b0;
        tx_data  = '0;
        rx_rd    = 1'b0;
        done     = 1'b0;
        busy     = (state_q != ST_IDLE);
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (op_e'(op) == OP_RSVD) begin
                        state_d = ST_FINISH;
                    end else begin
                        ser_load = 1'b1;
                        state_d  = ST_SEND_CMD;
                    end
                end
            end
            ST_SEND_CMD: begin
                tx_wr   = ser_valid;
                tx_data = DATA_W'(ser_data);
                if (ser_last) begin
                    case (op_q)
                        OP_TX_TEST: state_d = ST_RECV_DATA;
                        OP_RX_TEST: state_d = ST_SEND_DATA;
                        default:    state_d = ST_FINISH;
                    endcase
                end
            end
            ST_SEND_DATA: begin
                tx_wr   = 1'b1;
                tx_data = pay_q;
                if (!tx_full && beat_last)
                    state_d = ST_RECV_STATUS;
            end
            ST_RECV_DATA: begin
                rx_rd = !rx_empty;
                if (rx_valid) begin
                    if (beat_last)
                        state_d = ST_FINISH;
                end else if (tmo_hit) begin
                    state_d = ST_FINISH;
                end
            end
            ST_RECV_STATUS: begin
                rx_rd = !rx_empty;
                if (rx_valid || tmo_hit)
                    state_d = ST_FINISH;
            end
            ST_FINISH: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q <= ST_IDLE;
            op_q    <= OP_TX_TEST;
            n_q     <= '0;
            beat_q  <= '0;
            exp_q   <= '0;
            pay_q   <= '0;
            tmo_q   <= '0;
            err_cnt <= '0;
            pass    <= 1'b0;
            timeout <= 1'b0;
        end else begin
            state_q <= state_d;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        op_q    <= op_e'(op);
                        n_q     <= arg_eff;
                        beat_q  <= '0;
                        exp_q   <= '0;
                        pay_q   <= '0;
                        tmo_q   <= '0;
                        err_cnt <= '0;
                        pass    <= 1'b0;
                        timeout <= 1'b0;
                    end
                end
                ST_SEND_CMD: begin
                    if (ser_last) begin
                        tmo_q <= '0;
                        if (op_q == OP_LED)
                            pass <= 1'b1;
                    end
                end
                ST_SEND_DATA: begin
                    if (!tx_full) begin
                        pay_q  <= pay_q + 1'b1;
                        beat_q <= beat_q + 33'd1;
                        tmo_q  <= '0;
                    end
                end
                ST_RECV_DATA: begin
                    if (rx_valid) begin
                        tmo_q   <= '0;
                        exp_q   <= exp_q + 1'b1;
                        beat_q  <= beat_q + 33'd1;
                        err_cnt <= err_next;
                        if (beat_last)
                            pass <= (err_next == 32'd0);
                    end else begin
                        tmo_q <= tmo_q + 32'd1;
                        if (tmo_hit) begin
                            timeout <= 1'b1;
                            pass    <= 1'b0;
                        end
                    end
                end
                ST_RECV_STATUS: begin
                    if (rx_valid) begin
                        tmo_q   <= '0;
                        pass    <= (rx_data == DATA_W'(STATUS_PASS));
                        err_cnt <= (rx_data == DATA_W'(STATUS_PASS)) ? 32'd0 : 32'd1;
                    end else begin
                        tmo_q <= tmo_q + 32'd1;
                        if (tmo_hit) begin
                            timeout <= 1'b1;
                            pass    <= 1'b0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ft_cmd_initiator.sv
// Scoreboard bench: directed tests push expected wire bytes and results; monitors pop and compare.
module tb_ft_cmd_initiator;
    import ft_test_pkg::*;

    logic        sys_clk = 1'b0;
    logic        sys_rst = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  op = 2'd0;
    logic [31:0] arg = 32'd0;
    logic        busy, done, pass, timeout;
    logic [31:0] err_cnt;
    logic [7:0]  tx_data;
    logic        tx_wr;
    logic        tx_full = 1'b0;
    logic        rx_rd;
    logic        rx_empty = 1'b1;
    logic [7:0]  rx_data = 8'd0;
    logic        rx_valid = 1'b0;

    typedef struct {
        logic        p;
        logic [31:0] e;
        logic        t;
    } res_t;

    int         n_cmp = 0;
    int         n_bad = 0;
    logic [7:0] exp_tx[$];
    res_t       exp_res[$];
    logic [7:0] rx_q[$];
    logic [7:0] pend_q[$];
    int         rd_cnt = 0;
    int         stray_req = 0;
    int         stray_done = 0;
    bit         full_rand = 1'b0;

    ft_cmd_initiator #(.DATA_W(8), .TIMEOUT_CYC(100)) dut (
        .sys_clk  (sys_clk),
        .sys_rst  (sys_rst),
        .start    (start),
        .op       (op),
        .arg      (arg),
        .busy     (busy),
        .done     (done),
        .pass     (pass),
        .err_cnt  (err_cnt),
        .timeout  (timeout),
        .tx_data  (tx_data),
        .tx_wr    (tx_wr),
        .tx_full  (tx_full),
        .rx_rd    (rx_rd),
        .rx_empty (rx_empty),
        .rx_data  (rx_data),
        .rx_valid (rx_valid)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic issue(input logic [1:0] o, input logic [31:0] a);
        tick();
        start = 1'b1;
        op    = o;
        arg   = a;
        tick();
        start = 1'b0;
    endtask

    task automatic push_frame(input logic [63:0] f);
        for (int i = 7; i >= 0; i--)
            exp_tx.push_back(f[8*i +: 8]);
    endtask

    task automatic push_res(input logic p, input logic [31:0] e, input logic t);
        res_t r;
        r.p = p;
        r.e = e;
        r.t = t;
        exp_res.push_back(r);
    endtask

    // exp_cyc < 0 skips the latency comparison for randomly-timed tests.
    task automatic wait_done(input string name, input int limit, input int exp_cyc);
        int c;
        c = 0;
        do begin
            @(negedge sys_clk);
            c++;
        end while (!done && c < limit);
        if (!done) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s: no done within %0d cycles", name, limit);
        end else if (exp_cyc >= 0) begin
            check({name, "_latency"}, c, exp_cyc);
        end
        tick();
        tick();
    endtask

    // Responder: FIFO of response bytes, random delivery latency, optional stray beats.
    initial begin
        bit do_rd;
        forever begin
            @(negedge sys_clk);
            do_rd = rx_rd && !rx_empty;
            @(posedge sys_clk);
            #1;
            if (do_rd) begin
                pend_q.push_back(rx_q.pop_front());
                rd_cnt++;
            end
            rx_valid = 1'b0;
            if (pend_q.size() > 0 && $urandom_range(0, 1) == 1) begin
                rx_valid = 1'b1;
                rx_data  = pend_q.pop_front();
            end else if (stray_done < stray_req) begin
                rx_valid = 1'b1;
                rx_data  = 8'h99;
                stray_done++;
            end
            rx_empty = (rx_q.size() == 0);
            tx_full  = full_rand ? 1'($urandom_range(0, 1)) : 1'b0;
        end
    end

    // Write-side monitor: byte order and hold-under-backpressure.
    initial begin
        bit         prev_stall;
        logic [7:0] prev_data;
        prev_stall = 1'b0;
        prev_data  = 8'd0;
        forever begin
            @(negedge sys_clk);
            if (prev_stall) begin
                check("tx_hold_wr", tx_wr, 1);
                check("tx_hold_data", tx_data, prev_data);
            end
            if (tx_wr && !tx_full) begin
                if (exp_tx.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL tx_unexpected: got byte %0h expected no write", tx_data);
                end else begin
                    check("tx_byte", tx_data, exp_tx.pop_front());
                end
            end
            prev_stall = tx_wr && tx_full && !sys_rst;
            prev_data  = tx_data;
        end
    end

    // Result monitor: compares pass/err_cnt/timeout whenever done pulses.
    initial begin
        res_t r;
        forever begin
            @(negedge sys_clk);
            if (done) begin
                if (exp_res.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL done_unexpected: got done=1 expected no done");
                end else begin
                    r = exp_res.pop_front();
                    check("res_pass", pass, r.p);
                    check("res_err_cnt", err_cnt, r.e);
                    check("res_timeout", timeout, r.t);
                    check("rx_rd_at_done", rx_rd, 0);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish before 50000 cycles");
        $fatal(1, "watchdog");
    end

    initial begin
        int r0;

        repeat (3) tick();
        @(negedge sys_clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_tx_wr", tx_wr, 0);
        check("rst_tx_data", tx_data, 0);
        check("rst_rx_rd", rx_rd, 0);
        check("rst_pass", pass, 0);
        check("rst_err_cnt", err_cnt, 0);
        check("rst_timeout", timeout, 0);
        tick();
        sys_rst = 1'b0;

        // LED with stray rx beats that must be ignored
        push_frame(64'h55_01_00_00_00_D0_1E_AA);
        push_res(1'b1, 32'd0, 1'b0);
        issue(2'd2, 32'd1);
        stray_req = 2;
        wait_done("led", 30, 9);

        // reserved op: immediate done, nothing sent
        push_res(1'b0, 32'd0, 1'b0);
        issue(2'd3, 32'h1234_5678);
        wait_done("rsvd", 10, 1);

        // TX_TEST N=300: expected byte wraps after 0xFF
        push_frame(64'h55_2C_01_00_00_EF_BE_AA);
        for (int k = 0; k <= 300; k++)
            rx_q.push_back(8'(k));
        push_res(1'b1, 32'd0, 1'b0);
        r0 = rd_cnt;
        issue(2'd0, 32'd300);
        wait_done("tx300", 4000, -1);
        check("tx300_reads", rd_cnt - r0, 301);

        // TX_TEST N=3 with byte 2 corrupted
        push_frame(64'h55_03_00_00_00_EF_BE_AA);
        rx_q.push_back(8'h00);
        rx_q.push_back(8'h01);
        rx_q.push_back(8'h77);
        rx_q.push_back(8'h03);
        push_res(1'b0, 32'd1, 1'b0);
        issue(2'd0, 32'd3);
        wait_done("tx3_corrupt", 200, -1);

        // RX_TEST N=4 under random backpressure, good then bad status
        full_rand = 1'b1;
        push_frame(64'h55_04_00_00_00_FE_CA_AA);
        for (int k = 0; k <= 4; k++)
            exp_tx.push_back(8'(k));
        rx_q.push_back(STATUS_PASS);
        push_res(1'b1, 32'd0, 1'b0);
        issue(2'd1, 32'd4);
        wait_done("rx4_pass", 300, -1);

        push_frame(64'h55_04_00_00_00_FE_CA_AA);
        for (int k = 0; k <= 4; k++)
            exp_tx.push_back(8'(k));
        rx_q.push_back(STATUS_FAIL);
        push_res(1'b0, 32'd1, 1'b0);
        issue(2'd1, 32'd4);
        wait_done("rx4_fail", 300, -1);
        full_rand = 1'b0;
        tick();

        // TX_TEST with a silent responder: timeout 100 cycles after RECV_DATA entry
        push_frame(64'h55_05_00_00_00_EF_BE_AA);
        push_res(1'b0, 32'd0, 1'b1);
        issue(2'd0, 32'd5);
        wait_done("timeout", 300, 109);

        // reset while frame byte 4 is on the wire
        exp_tx.push_back(8'h55);
        exp_tx.push_back(8'h01);
        exp_tx.push_back(8'h00);
        exp_tx.push_back(8'h00);
        exp_tx.push_back(8'h00);
        issue(2'd2, 32'd1);
        for (int i = 0; i < 4; i++) begin
            @(negedge sys_clk);
            check("mid_busy", busy, 1);
        end
        tick();
        sys_rst = 1'b1;
        tick();
        sys_rst = 1'b0;
        @(negedge sys_clk);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_tx_wr", tx_wr, 0);
        check("abort_tx_data", tx_data, 0);
        check("abort_timeout", timeout, 0);
        check("abort_pass", pass, 0);
        repeat (5) tick();

        push_frame(64'h55_00_00_00_00_D0_1E_AA);
        push_res(1'b1, 32'd0, 1'b0);
        issue(2'd2, 32'd0);
        wait_done("led_after_rst", 30, 9);

        repeat (3) tick();
        check("left_tx", exp_tx.size(), 0);
        check("left_res", exp_res.size(), 0);
        check("left_rx", rx_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
